mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 171 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single RAM controller.
// Every output is registered and driven from next-value logic computed in one combinational process.
module mem_arbiter #(
   parameter int ADDR_W     = 4,
   parameter int DATA_W     = 8,
   parameter int WR_CYCLES  = 4,
   parameter int RD_TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              done0,
   output logic              done1,
   output logic [DATA_W-1:0] rdata,
   output logic              err,
   output logic              mc_read,
   output logic              mc_write,
   output logic [ADDR_W-1:0] mc_addr,
   output logic [DATA_W-1:0] mc_wdata,
   input  logic [DATA_W-1:0] mc_rdata,
   input  logic              mc_read_ready,
   output logic              busy
);

   // One counter serves both the write hold and the read timeout.
   localparam int CNT_MAX = (WR_CYCLES > RD_TIMEOUT) ? WR_CYCLES : RD_TIMEOUT;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_CYCLES - 1);
   localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_TIMEOUT - 1);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_WR,
      WAIT_RD,
      DONE
   } state_t;

   state_t            state, state_d;
   logic [CNT_W-1:0]  cnt, cnt_d;
   logic              served, served_d;
   logic              we_lat, we_lat_d;
   logic              last_gnt, last_gnt_d;
   logic [ADDR_W-1:0] addr_d;
   logic [DATA_W-1:0] wdata_d;
   logic [DATA_W-1:0] rdata_d;
   logic              gnt0_d, gnt1_d, done0_d, done1_d, err_d;
   logic              mc_read_d, mc_write_d, busy_d;
   logic              pick;
   logic              pick_we;

   // On a tie the port that was not served last wins.
   assign pick    = (req0 && req1) ? ~last_gnt : req1;
   assign pick_we = pick ? we1 : we0;

   always_comb begin
      state_d    = state;
      cnt_d      = cnt;
      served_d   = served;
      we_lat_d   = we_lat;
      last_gnt_d = last_gnt;
      addr_d     = mc_addr;
      wdata_d    = mc_wdata;
      rdata_d    = rdata;
      gnt0_d     = 1'b0;
      gnt1_d     = 1'b0;
      done0_d    = 1'b0;
      done1_d    = 1'b0;
      err_d      = 1'b0;
      mc_read_d  = 1'b0;
      mc_write_d = 1'b0;
      unique case (state)
         IDLE: begin
            if (req0 || req1) begin
               served_d   = pick;
               we_lat_d   = pick_we;
               addr_d     = pick ? addr1 : addr0;
               wdata_d    = pick ? wdata1 : wdata0;
               gnt0_d     = ~pick;
               gnt1_d     = pick;
               mc_write_d = pick_we;
               mc_read_d  = ~pick_we;
               state_d    = ISSUE;
            end
         end
         ISSUE: begin
            cnt_d   = '0;
            state_d = we_lat ? WAIT_WR : WAIT_RD;
         end
         WAIT_WR: begin
            if (cnt == WR_LAST) begin
               state_d = DONE;
               done0_d = ~served;
               done1_d = served;
            end else begin
               cnt_d = cnt + CNT_W'(1);
            end
         end
         WAIT_RD: begin
            if (mc_read_ready) begin
               rdata_d = mc_rdata;
               state_d = DONE;
               done0_d = ~served;
               done1_d = served;
            end else if (cnt == RD_LAST) begin
               err_d   = 1'b1;
               state_d = DONE;
               done0_d = ~served;
               done1_d = served;
            end else begin
               cnt_d = cnt + CNT_W'(1);
            end
         end
         DONE: begin
            last_gnt_d = served;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy_d = (state_d != IDLE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         cnt      <= '0;
         served   <= 1'b0;
         we_lat   <= 1'b0;
         last_gnt <= 1'b1;
         mc_addr  <= '0;
         mc_wdata <= '0;
         rdata    <= '0;
         gnt0     <= 1'b0;
         gnt1     <= 1'b0;
         done0    <= 1'b0;
         done1    <= 1'b0;
         err      <= 1'b0;
         mc_read  <= 1'b0;
         mc_write <= 1'b0;
         busy     <= 1'b0;
      end else begin
         state    <= state_d;
         cnt      <= cnt_d;
         served   <= served_d;
         we_lat   <= we_lat_d;
         last_gnt <= last_gnt_d;
         mc_addr  <= addr_d;
         mc_wdata <= wdata_d;
         rdata    <= rdata_d;
         gnt0     <= gnt0_d;
         gnt1     <= gnt1_d;
         done0    <= done0_d;
         done1    <= done1_d;
         err      <= err_d;
         mc_read  <= mc_read_d;
         mc_write <= mc_write_d;
         busy     <= busy_d;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, contention and reset sequences,
// and randomized transactions predicted by a transaction-level model (port choice, latency, err, rdata).
module tb_mem_arbiter;

   localparam int ADDR_W     = 4;
   localparam int DATA_W     = 8;
   localparam int WR_CYCLES  = 4;
   localparam int RD_TIMEOUT = 15;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              req0, req1, we0, we1;
   logic [ADDR_W-1:0] addr0, addr1;
   logic [DATA_W-1:0] wdata0, wdata1;
   logic              gnt0, gnt1, done0, done1, err;
   logic [DATA_W-1:0] rdata;
   logic              mc_read, mc_write;
   logic [ADDR_W-1:0] mc_addr;
   logic [DATA_W-1:0] mc_wdata;
   logic [DATA_W-1:0] mc_rdata;
   logic              mc_read_ready;
   logic              busy;

   int n_checks = 0;
   int n_fails  = 0;

   // Reference model state: last served port and last successfully read data.
   logic              m_last;
   logic [DATA_W-1:0] m_rdata;

   typedef struct {
      logic              r0, r1, w0, w1;
      logic [ADDR_W-1:0] a0, a1;
      logic [DATA_W-1:0] d0, d1;
      int                delay;
      logic [DATA_W-1:0] strobe_data;
      int                exp_port;
      int                exp_lat;
      logic              exp_err;
      logic [DATA_W-1:0] exp_rdata;
   } vec_t;

   vec_t vecs[8];

   mem_arbiter #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W),
      .WR_CYCLES(WR_CYCLES),
      .RD_TIMEOUT(RD_TIMEOUT)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .req0(req0),
      .req1(req1),
      .we0(we0),
      .we1(we1),
      .addr0(addr0),
      .addr1(addr1),
      .wdata0(wdata0),
      .wdata1(wdata1),
      .gnt0(gnt0),
      .gnt1(gnt1),
      .done0(done0),
      .done1(done1),
      .rdata(rdata),
      .err(err),
      .mc_read(mc_read),
      .mc_write(mc_write),
      .mc_addr(mc_addr),
      .mc_wdata(mc_wdata),
      .mc_rdata(mc_rdata),
      .mc_read_ready(mc_read_ready),
      .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic waitCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fails++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic r0, input logic r1, input logic w0, input logic w1,
                                input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
                                input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1);
      req0   = r0;
      req1   = r1;
      we0    = w0;
      we1    = w1;
      addr0  = a0;
      addr1  = a1;
      wdata0 = d0;
      wdata1 = d1;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_gnt0"}, 32'(gnt0), 0);
      checkOutput({tag, "_gnt1"}, 32'(gnt1), 0);
      checkOutput({tag, "_done0"}, 32'(done0), 0);
      checkOutput({tag, "_done1"}, 32'(done1), 0);
      checkOutput({tag, "_err"}, 32'(err), 0);
      checkOutput({tag, "_busy"}, 32'(busy), 0);
      checkOutput({tag, "_mc_read"}, 32'(mc_read), 0);
      checkOutput({tag, "_mc_write"}, 32'(mc_write), 0);
      checkOutput({tag, "_mc_addr"}, 32'(mc_addr), 0);
      checkOutput({tag, "_mc_wdata"}, 32'(mc_wdata), 0);
      checkOutput({tag, "_rdata"}, 32'(rdata), 0);
   endtask

   // Starts in an IDLE cycle, runs one transaction to completion and leaves the DUT in IDLE.
   task automatic runTransaction(input vec_t v);
      logic              e_we;
      logic [ADDR_W-1:0] e_addr;
      logic [DATA_W-1:0] e_wdata;
      bit                seen;
      e_we    = (v.exp_port == 1) ? v.w1 : v.w0;
      e_addr  = (v.exp_port == 1) ? v.a1 : v.a0;
      e_wdata = (v.exp_port == 1) ? v.d1 : v.d0;
      applyStimulus(v.r0, v.r1, v.w0, v.w1, v.a0, v.a1, v.d0, v.d1);
      waitCycle();
      checkOutput("gnt0", 32'(gnt0), 32'(v.exp_port == 0));
      checkOutput("gnt1", 32'(gnt1), 32'(v.exp_port == 1));
      checkOutput("mc_write", 32'(mc_write), 32'(e_we));
      checkOutput("mc_read", 32'(mc_read), 32'(!e_we));
      checkOutput("mc_addr", 32'(mc_addr), 32'(e_addr));
      checkOutput("mc_wdata", 32'(mc_wdata), 32'(e_wdata));
      checkOutput("issue_busy", 32'(busy), 1);
      seen = 1'b0;
      for (int k = 1; k <= 40 && !seen; k++) begin
         waitCycle();
         checkOutput("rd_wr_excl", 32'(mc_read & mc_write), 0);
         if (done0 || done1) begin
            seen = 1'b1;
            checkOutput("latency", 32'(k), 32'(v.exp_lat));
            checkOutput("done0", 32'(done0), 32'(v.exp_port == 0));
            checkOutput("done1", 32'(done1), 32'(v.exp_port == 1));
            checkOutput("err", 32'(err), 32'(v.exp_err));
            checkOutput("rdata", 32'(rdata), 32'(v.exp_rdata));
            checkOutput("mc_addr_hold", 32'(mc_addr), 32'(e_addr));
            checkOutput("done_busy", 32'(busy), 1);
            req0          = 1'b0;
            req1          = 1'b0;
            mc_read_ready = 1'b0;
         end else begin
            if (k == 1)
               checkOutput("pulse_width", 32'({gnt0, gnt1, mc_read, mc_write}), 0);
            mc_read_ready = (k == v.delay);
            mc_rdata      = (k == v.delay) ? v.strobe_data : DATA_W'($urandom);
         end
      end
      if (!seen) begin
         n_checks++;
         n_fails++;
         $display("[TB] FAIL done_timeout: no done within 40 cycles, required latency %0d", v.exp_lat);
         req0          = 1'b0;
         req1          = 1'b0;
         mc_read_ready = 1'b0;
      end
      waitCycle();
      checkOutput("idle_busy", 32'(busy), 0);
      checkOutput("idle_done", 32'(done0 | done1), 0);
      m_last  = (v.exp_port == 1);
      m_rdata = v.exp_rdata;
   endtask

   initial begin
      int   gnt_port[$];
      int   gnt_cyc[$];
      vec_t rv;
      logic sel, sel_we;

      reset_n       = 1'b0;
      mc_read_ready = 1'b0;
      mc_rdata      = '0;
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 4'h1, 4'h2, 8'h10, 8'h20);
      waitCycle();
      waitCycle();
      checkAllZero("reset");

      // Both requests held from reset release: grants alternate with a 7-cycle period.
      reset_n = 1'b1;
      for (int j = 1; j <= 30; j++) begin
         waitCycle();
         checkOutput("cont_rd_wr_excl", 32'(mc_read & mc_write), 0);
         checkOutput("cont_gnt_excl", 32'(gnt0 & gnt1), 0);
         if (gnt0 || gnt1) begin
            gnt_port.push_back(gnt1 ? 1 : 0);
            gnt_cyc.push_back(j);
         end
      end
      checkOutput("cont_grant_count", 32'(gnt_port.size()), 5);
      for (int i = 0; i < gnt_port.size() && i < 5; i++) begin
         checkOutput("cont_grant_port", 32'(gnt_port[i]), 32'(i % 2));
         checkOutput("cont_grant_cycle", 32'(gnt_cyc[i]), 32'(1 + 7 * i));
      end
      req0 = 1'b0;
      req1 = 1'b0;
      for (int j = 0; j < 20 && busy; j++)
         waitCycle();
      checkOutput("cont_drain_busy", 32'(busy), 0);
      m_last  = 1'b0;
      m_rdata = '0;

      // r0 r1 w0 w1 a0 a1 d0 d1 delay strobe port lat err rdata
      vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'h3, 4'h0, 8'hA5, 8'h00,  2, 8'hFF, 0,  5, 1'b0, 8'h00};
      vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h7, 8'h00, 8'h00,  3, 8'h3C, 1,  4, 1'b0, 8'h3C};
      vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 4'h1, 4'h2, 8'h11, 8'h22,  0, 8'h00, 0,  5, 1'b0, 8'h3C};
      vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'h1, 4'h9, 8'h33, 8'h44,  1, 8'h5A, 1,  2, 1'b0, 8'h5A};
      vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h4, 4'h0, 8'h55, 8'h00,  0, 8'h00, 0, 16, 1'b1, 8'h5A};
      vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h8, 8'h00, 8'h66, 15, 8'hC3, 1, 16, 1'b0, 8'hC3};
      vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'hA, 4'h0, 8'h00, 8'h00, 16, 8'h11, 0, 16, 1'b1, 8'hC3};
      vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 4'h5, 4'hF, 8'h99, 8'h77,  0, 8'h00, 1,  5, 1'b0, 8'hC3};
      for (int i = 0; i < 8; i++)
         runTransaction(vecs[i]);

      // Read-complete strobe while idle must be ignored.
      mc_read_ready = 1'b1;
      mc_rdata      = 8'hFF;
      for (int j = 0; j < 3; j++) begin
         waitCycle();
         checkOutput("stray_busy", 32'(busy), 0);
         checkOutput("stray_gnt", 32'(gnt0 | gnt1), 0);
         checkOutput("stray_rdata", 32'(rdata), 32'(m_rdata));
      end
      mc_read_ready = 1'b0;

      for (int n = 0; n < 40; n++) begin
         rv.r0 = 1'($urandom);
         rv.r1 = 1'($urandom);
         if (!rv.r0 && !rv.r1)
            rv.r0 = 1'b1;
         rv.w0          = 1'($urandom);
         rv.w1          = 1'($urandom);
         rv.a0          = ADDR_W'($urandom);
         rv.a1          = ADDR_W'($urandom);
         rv.d0          = DATA_W'($urandom);
         rv.d1          = DATA_W'($urandom);
         rv.strobe_data = DATA_W'($urandom);
         sel            = (rv.r0 && rv.r1) ? !m_last : rv.r1;
         sel_we         = sel ? rv.w1 : rv.w0;
         rv.exp_port    = sel ? 1 : 0;
         if (sel_we) begin
            rv.delay     = int'($urandom_range(0, WR_CYCLES + 1));
            rv.exp_lat   = WR_CYCLES + 1;
            rv.exp_err   = 1'b0;
            rv.exp_rdata = m_rdata;
         end else begin
            rv.delay = int'($urandom_range(0, RD_TIMEOUT + 3));
            if (rv.delay >= 1 && rv.delay <= RD_TIMEOUT) begin
               rv.exp_lat   = rv.delay + 1;
               rv.exp_err   = 1'b0;
               rv.exp_rdata = rv.strobe_data;
            end else begin
               rv.exp_lat   = RD_TIMEOUT + 1;
               rv.exp_err   = 1'b1;
               rv.exp_rdata = m_rdata;
            end
         end
         runTransaction(rv);
      end

      // Reset asserted during WAIT_RD aborts the read; a pending req0 is then served.
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h5, 8'h00, 8'h00);
      waitCycle();
      checkOutput("rst_gnt1", 32'(gnt1), 1);
      req0   = 1'b1;
      we0    = 1'b1;
      addr0  = 4'h6;
      wdata0 = 8'h42;
      waitCycle();
      waitCycle();
      #2;
      reset_n = 1'b0;
      #1;
      checkAllZero("midrst");
      for (int j = 0; j < 3; j++) begin
         waitCycle();
         checkOutput("midrst_no_done", 32'(done0 | done1), 0);
      end
      reset_n = 1'b1;
      m_last  = 1'b1;
      m_rdata = '0;
      rv = '{1'b1, 1'b0, 1'b1, 1'b0, 4'h6, 4'h5, 8'h42, 8'h00, 0, 8'h00, 0, 5, 1'b0, 8'h00};
      runTransaction(rv);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
